// File: rtl/imem_port_arbiter.sv
// Shares the single-port instruction memory between fetch and loader.
// Loader has priority; fetch waits at most MAX_LD_BURST loader grants.
module imem_port_arbiter #(
  parameter int ADDR_W       = 7,
  parameter int DATA_W       = 32,
  parameter int MAX_LD_BURST = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic              ld_gnt,
  output logic              ld_ack,
  output logic [DATA_W-1:0] ld_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_datain,
  output logic              mem_sigwr,
  output logic              mem_sigon,
  input  logic [DATA_W-1:0] mem_dataout
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_LD   = 2'd2
  } own_t;

  localparam logic [3:0] MAX_CNT = 4'(MAX_LD_BURST);

  own_t       rsp_own;
  own_t       own_nxt;
  logic [3:0] starve_cnt;
  logic [3:0] starve_nxt;
  logic       fetch_win;
  logic       load_win;

  always_comb begin
    fetch_win = 1'b0;
    load_win  = 1'b0;
    if (rst_n) begin
      if (if_req && ld_req) begin
        fetch_win = (starve_cnt == MAX_CNT);
        load_win  = (starve_cnt != MAX_CNT);
      end else begin
        fetch_win = if_req;
        load_win  = ld_req;
      end
    end
  end

  assign if_gnt = fetch_win;
  assign ld_gnt = load_win;

  always_comb begin
    mem_sigon  = 1'b0;
    mem_sigwr  = 1'b0;
    mem_addr   = '0;
    mem_datain = '0;
    own_nxt    = OWN_NONE;
    unique case (1'b1)
      fetch_win: begin
        mem_sigon = 1'b1;
        mem_addr  = if_addr;
        own_nxt   = OWN_IF;
      end
      load_win: begin
        mem_sigon  = 1'b1;
        mem_sigwr  = ld_we;
        mem_addr   = ld_addr;
        mem_datain = ld_we ? ld_wdata : '0;
        own_nxt    = OWN_LD;
      end
      default: ;
    endcase
  end

  // A waiting fetch counts loader wins; any fetch win or idle fetch clears it.
  always_comb begin
    starve_nxt = starve_cnt;
    if (!if_req || fetch_win)
      starve_nxt = '0;
    else if (load_win && starve_cnt != MAX_CNT)
      starve_nxt = starve_cnt + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_own    <= OWN_NONE;
      starve_cnt <= '0;
    end else begin
      rsp_own    <= own_nxt;
      starve_cnt <= starve_nxt;
    end
  end

  assign if_rvalid = (rsp_own == OWN_IF);
  assign ld_ack    = (rsp_own == OWN_LD);
  assign if_rdata  = if_rvalid ? mem_dataout : '0;
  assign ld_rdata  = ld_ack ? mem_dataout : '0;

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Directed bench for imem_port_arbiter with a 128x32 synchronous
// memory model that echoes write data.
module tb_imem_port_arbiter;

  logic        clk;
  logic        rst_n;
  logic        if_req;
  logic [6:0]  if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        ld_req;
  logic        ld_we;
  logic [6:0]  ld_addr;
  logic [31:0] ld_wdata;
  logic        ld_gnt;
  logic        ld_ack;
  logic [31:0] ld_rdata;
  logic [6:0]  mem_addr;
  logic [31:0] mem_datain;
  logic        mem_sigwr;
  logic        mem_sigon;
  logic [31:0] mem_dataout;

  int vecs = 0;
  int errs = 0;

  imem_port_arbiter #(
    .ADDR_W(7),
    .DATA_W(32),
    .MAX_LD_BURST(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .if_req(if_req),
    .if_addr(if_addr),
    .if_gnt(if_gnt),
    .if_rvalid(if_rvalid),
    .if_rdata(if_rdata),
    .ld_req(ld_req),
    .ld_we(ld_we),
    .ld_addr(ld_addr),
    .ld_wdata(ld_wdata),
    .ld_gnt(ld_gnt),
    .ld_ack(ld_ack),
    .ld_rdata(ld_rdata),
    .mem_addr(mem_addr),
    .mem_datain(mem_datain),
    .mem_sigwr(mem_sigwr),
    .mem_sigon(mem_sigon),
    .mem_dataout(mem_dataout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] pre(int i);
    return 32'hC0DE_0000 | 32'(i);
  endfunction

  logic [31:0] mem [128];
  logic [31:0] mem_q;
  assign mem_dataout = mem_q;

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = pre(i);
    mem_q = '0;
    forever begin
      @(posedge clk);
      if (mem_sigon) begin
        if (mem_sigwr) begin
          mem[mem_addr] = mem_datain;
          mem_q = mem_datain;
        end else begin
          mem_q = mem[mem_addr];
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    if_req = 1'b1;
    ld_req = 1'b1;
    ld_we = 1'b0;
    if_addr = 7'd3;
    ld_addr = 7'd5;
    ld_wdata = '0;
    for (int k = 0; k < 3; k++) begin
      tick();
      #1;
      vecs++;
      if ({if_gnt, ld_gnt, mem_sigon, if_rvalid, ld_ack} !== 5'b0) begin
        errs++;
        $display("FAIL reset_ctl[%0d]: got %b want 00000", k,
                 {if_gnt, ld_gnt, mem_sigon, if_rvalid, ld_ack});
      end
      vecs++;
      if ({mem_addr, mem_datain, mem_sigwr, if_rdata, ld_rdata} !== '0) begin
        errs++;
        $display("FAIL reset_data[%0d]: got addr %h din %h wr %b ifd %h ldd %h want 0",
                 k, mem_addr, mem_datain, mem_sigwr, if_rdata, ld_rdata);
      end
    end
    rst_n = 1'b1;
    #1;
    vecs++;
    if ({if_gnt, ld_gnt} !== 2'b01 || mem_addr !== 7'd5) begin
      errs++;
      $display("FAIL reset_release: got gnt %b addr %h want 01 05",
               {if_gnt, ld_gnt}, mem_addr);
    end
    tick();
    if_req = 1'b0;
    ld_req = 1'b0;
    #1;
    vecs++;
    if (ld_ack !== 1'b1 || ld_rdata !== pre(5) || if_rvalid !== 1'b0) begin
      errs++;
      $display("FAIL reset_first_ack: got ack %b data %h rv %b want 1 %h 0",
               ld_ack, ld_rdata, if_rvalid, pre(5));
    end
    tick();
    #1;
    vecs++;
    if (ld_ack !== 1'b0 || ld_rdata !== 32'h0) begin
      errs++;
      $display("FAIL idle_ack: got ack %b data %h want 0 0", ld_ack, ld_rdata);
    end
  endtask

  task automatic test_fetch_stream();
    for (int k = 0; k < 4; k++) begin
      if_req = (k < 3);
      if_addr = 7'(k);
      #1;
      vecs++;
      if (if_gnt !== (k < 3) || ld_gnt !== 1'b0) begin
        errs++;
        $display("FAIL fetch_gnt[%0d]: got %b%b want %b0", k, if_gnt, ld_gnt, k < 3);
      end
      vecs++;
      if (if_rvalid !== (k > 0) || if_rdata !== ((k > 0) ? pre(k - 1) : 32'h0)) begin
        errs++;
        $display("FAIL fetch_rsp[%0d]: got rv %b data %h want %b %h", k, if_rvalid,
                 if_rdata, k > 0, (k > 0) ? pre(k - 1) : 32'h0);
      end
      tick();
    end
  endtask

  task automatic test_loader_rw();
    ld_req = 1'b1;
    ld_we = 1'b1;
    ld_addr = 7'd9;
    ld_wdata = 32'hDEADBEEF;
    #1;
    vecs++;
    if ({ld_gnt, mem_sigon, mem_sigwr} !== 3'b111 || mem_datain !== 32'hDEADBEEF
        || mem_addr !== 7'd9) begin
      errs++;
      $display("FAIL ld_write_issue: got %b din %h addr %h want 111 deadbeef 09",
               {ld_gnt, mem_sigon, mem_sigwr}, mem_datain, mem_addr);
    end
    tick();
    ld_we = 1'b0;
    ld_wdata = 32'h12345678;
    #1;
    vecs++;
    if (mem_sigwr !== 1'b0 || mem_datain !== 32'h0 || ld_gnt !== 1'b1) begin
      errs++;
      $display("FAIL ld_read_issue: got wr %b din %h gnt %b want 0 0 1",
               mem_sigwr, mem_datain, ld_gnt);
    end
    vecs++;
    if (ld_ack !== 1'b1 || ld_rdata !== 32'hDEADBEEF || if_rvalid !== 1'b0) begin
      errs++;
      $display("FAIL ld_write_ack: got ack %b data %h rv %b want 1 deadbeef 0",
               ld_ack, ld_rdata, if_rvalid);
    end
    tick();
    ld_req = 1'b0;
    #1;
    vecs++;
    if (ld_ack !== 1'b1 || ld_rdata !== 32'hDEADBEEF || if_rvalid !== 1'b0) begin
      errs++;
      $display("FAIL ld_read_ack: got ack %b data %h rv %b want 1 deadbeef 0",
               ld_ack, ld_rdata, if_rvalid);
    end
    tick();
  endtask

  task automatic test_starvation();
    logic exp_ld;
    logic prev_ld;
    prev_ld = 1'b0;
    if_req = 1'b1;
    ld_req = 1'b1;
    ld_we = 1'b0;
    if_addr = 7'h11;
    ld_addr = 7'h22;
    for (int k = 0; k < 10; k++) begin
      exp_ld = (k % 5) != 4;
      #1;
      vecs++;
      if ({if_gnt, ld_gnt} !== {!exp_ld, exp_ld}
          || mem_addr !== (exp_ld ? 7'h22 : 7'h11)) begin
        errs++;
        $display("FAIL starve_gnt[%0d]: got %b addr %h want %b %h", k,
                 {if_gnt, ld_gnt}, mem_addr, {!exp_ld, exp_ld},
                 exp_ld ? 7'h22 : 7'h11);
      end
      if (k > 0) begin
        vecs++;
        if ({if_rvalid, ld_ack} !== {!prev_ld, prev_ld}
            || (prev_ld ? ld_rdata : if_rdata) !== (prev_ld ? pre(34) : pre(17))) begin
          errs++;
          $display("FAIL starve_rsp[%0d]: got %b ifd %h ldd %h want %b", k,
                   {if_rvalid, ld_ack}, if_rdata, ld_rdata, {!prev_ld, prev_ld});
        end
      end
      prev_ld = exp_ld;
      tick();
    end
    if_req = 1'b0;
    ld_req = 1'b0;
    #1;
    vecs++;
    if (if_rvalid !== 1'b1 || if_rdata !== pre(17) || ld_ack !== 1'b0) begin
      errs++;
      $display("FAIL starve_last: got rv %b data %h ack %b want 1 %h 0",
               if_rvalid, if_rdata, ld_ack, pre(17));
    end
    tick();
  endtask

  task automatic test_counter_clear();
    logic [7:0] ifv;
    logic [7:0] ldw;
    ifv = 8'b1111_1011;
    ldw = 8'b0111_1111;
    ld_req = 1'b1;
    ld_we = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if_req = ifv[k];
      #1;
      vecs++;
      if ({if_gnt, ld_gnt} !== {!ldw[k], ldw[k]}) begin
        errs++;
        $display("FAIL clear_gnt[%0d]: got %b want %b", k, {if_gnt, ld_gnt},
                 {!ldw[k], ldw[k]});
      end
      tick();
    end
    if_req = 1'b0;
    ld_req = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset_mid();
    if_req = 1'b1;
    ld_req = 1'b0;
    if_addr = 7'd4;
    #1;
    vecs++;
    if (if_gnt !== 1'b1) begin
      errs++;
      $display("FAIL mid_gnt: got %b want 1", if_gnt);
    end
    #1;
    rst_n = 1'b0;
    tick();
    #1;
    vecs++;
    if ({if_rvalid, ld_ack, if_gnt, ld_gnt, mem_sigon} !== 5'b0
        || if_rdata !== 32'h0 || mem_addr !== 7'h0) begin
      errs++;
      $display("FAIL mid_suppress: got %b data %h addr %h want 00000 0 0",
               {if_rvalid, ld_ack, if_gnt, ld_gnt, mem_sigon}, if_rdata, mem_addr);
    end
    rst_n = 1'b1;
    #1;
    vecs++;
    if (if_gnt !== 1'b1 || mem_addr !== 7'd4) begin
      errs++;
      $display("FAIL mid_regrant: got %b addr %h want 1 04", if_gnt, mem_addr);
    end
    tick();
    if_req = 1'b0;
    #1;
    vecs++;
    if (if_rvalid !== 1'b1 || if_rdata !== pre(4)) begin
      errs++;
      $display("FAIL mid_rsp: got rv %b data %h want 1 %h", if_rvalid, if_rdata, pre(4));
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_fetch_stream();
    test_loader_rw();
    test_starvation();
    test_counter_clear();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/imem_port_arbiter.md
# imem_port_arbiter

Arbitration and sequencing front-end for the 128 x 32 single-port instruction memory. Shares the memory's one synchronous port between the instruction-fetch stage (read-only) and the program loader (read/write). Fixed loader priority with a bounded-starvation guarantee for fetch. Per-requester response tracking around the memory's one-cycle registered read.

## Interface
- ADDR_W, 7, memory word-address width
- DATA_W, 32, instruction/data word width
- MAX_LD_BURST, 4, max consecutive loader grants while fetch is waiting (1..15)

- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  reset, synchronous, active-low
- if_req  in  1  fetch read request, held until granted
- if_addr  in  ADDR_W  fetch word address
- if_gnt  out  1  fetch request accepted this cycle (combinational)
- if_rvalid  out  1  fetch read data valid
- if_rdata  out  DATA_W  fetch read data
- ld_req  in  1  loader request, held until granted
- ld_we  in  1  loader write (1) / read (0)
- ld_addr  in  ADDR_W  loader word address
- ld_wdata  in  DATA_W  loader write data
- ld_gnt  out  1  loader request accepted this cycle (combinational)
- ld_ack  out  1  loader access complete
- ld_rdata  out  DATA_W  loader read data (write data echoed on writes)
- mem_addr  out  ADDR_W  to memory addr
- mem_datain  out  DATA_W  to memory datain
- mem_sigwr  out  1  to memory sigwr
- mem_sigon  out  1  to memory sigon
- mem_dataout  in  DATA_W  from memory dataout

## Operation
- One access issued per cycle max; winner's request drives the memory port combinationally in the grant cycle.
- Arbitration each cycle (rst_n high):
  - only if_req: fetch wins.
  - only ld_req: loader wins.
  - both: loader wins unless starve_cnt == MAX_LD_BURST, then fetch wins.
  - neither: idle.
- starve_cnt (4-bit): on a loader grant with if_req high, increments, saturating at MAX_LD_BURST; cleared on any fetch grant or any cycle with if_req low.
- Fetch grant: mem_sigon=1, mem_sigwr=0, mem_addr=if_addr, mem_datain=0.
- Loader grant: mem_sigon=1, mem_sigwr=ld_we, mem_addr=ld_addr, mem_datain=ld_we ? ld_wdata : 0.
- Idle: mem_sigon=0, mem_sigwr=0, mem_addr=0, mem_datain=0.
- Response owner register rsp_own ∈ {NONE, IF, LD}: loaded each cycle with the current grant's owner (NONE when idle).
- if_rvalid = (rsp_own==IF); if_rdata = mem_dataout when if_rvalid, else 0.
- ld_ack = (rsp_own==LD); ld_rdata = mem_dataout when ld_ack, else 0. Memory echoes datain on a write, so a write ack returns the written word.
- Unaccepted requests are neither dropped nor latched. The requester keeps req/addr/data stable until its gnt.

## Timing
- Grant is combinational in cycle N. The memory samples on edge N→N+1. rvalid/ack and data are valid in cycle N+1: latency 1, throughput 1 access/cycle.
- Back-to-back grants to the same requester give consecutive rvalid/ack pulses, in order.
- Reset (rst_n low at an edge): rsp_own=NONE, starve_cnt=0.
- While rst_n is low, if_gnt, ld_gnt, and mem_sigon are forced 0. Mem outputs are 0.
- Out of reset, if_rvalid=0, ld_ack=0, and both rdata outputs are 0.
- Reset asserted with an access outstanding: that access's rvalid/ack is suppressed. The memory write itself has already happened if it was sampled before reset.
- Memory contents are not affected by reset.
- Fetch worst-case wait under continuous loader traffic: MAX_LD_BURST cycles.

## Test plan
- Reset: hold rst_n=0 three cycles with both req high -> both gnts 0, mem_sigon 0, if_rvalid/ld_ack 0. Release -> loader granted first cycle.
- Fetch-only stream: if_req held, if_addr 0,1,2 on consecutive cycles -> if_gnt every cycle. if_rvalid on cycles +1..+3 with if_rdata = mem[0..2] preload values.
- Loader write/read: write 0xDEADBEEF to addr 9, then read addr 9 -> ack after each. Write ack ld_rdata=0xDEADBEEF; read ack ld_rdata=0xDEADBEEF. No if_rvalid.
- Starvation bound: both req held continuously, MAX_LD_BURST=4 -> grant pattern L,L,L,L,F repeating. starve_cnt never exceeds 4.
- Counter clear: 2 loader grants while if_req high, then if_req low one cycle, then high -> counter restarts. Fetch is next granted only after 4 further loader grants.
- Reset mid-access: grant fetch at cycle N, rst_n=0 at edge N→N+1 -> no if_rvalid in N+1. Outputs at reset values.
